// File: rtl/vector_wb_queue_if.sv
// Handshake and payload bundle between the vector ALU, the write-back queue and the register file.
// The slave modport is the queue's view; master is the producer/consumer side.
interface vector_wb_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 5,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  valid_i;
  logic                  ready_o;
  logic                  mask_e_i;
  logic [DATA_WIDTH-1:0] alu_q_i;
  logic [DATA_WIDTH-1:0] old_vd_i;
  logic [4:0]            vd_i;
  logic [IDX_WIDTH-1:0]  elem_i;
  logic                  last_i;

  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [4:0]            wb_vd_o;
  logic [IDX_WIDTH-1:0]  wb_elem_o;
  logic                  wb_last_o;

  logic                  done_o;
  logic [CntW-1:0]       count_o;

  modport slave (
    input  valid_i, mask_e_i, alu_q_i, old_vd_i, vd_i, elem_i, last_i, wb_ready_i,
    output ready_o, wb_valid_o, wb_data_o, wb_vd_o, wb_elem_o, wb_last_o, done_o, count_o
  );

  modport master (
    output valid_i, mask_e_i, alu_q_i, old_vd_i, vd_i, elem_i, last_i, wb_ready_i,
    input  ready_o, wb_valid_o, wb_data_o, wb_vd_o, wb_elem_o, wb_last_o, done_o, count_o
  );
endinterface

// File: rtl/vector_wb_queue.sv
// Vector write-back queue: masked merge of ALU results into a small FIFO feeding the register file.
// Optional same-cycle bypass of an empty queue is enabled by defining WB_QUEUE_BYPASS_EN.
module vector_wb_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 5,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  vector_wb_queue_if.slave    bus
);
  localparam int unsigned     PtrW = $clog2(DEPTH);
  localparam int unsigned     CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [4:0]            r_vd   [DEPTH];
  logic [IDX_WIDTH-1:0]  r_elem [DEPTH];
  logic                  r_last [DEPTH];
  logic [PtrW-1:0]       r_wptr, r_rptr;
  logic [CntW-1:0]       r_count;
  logic                  r_done;

  logic                  w_empty, w_accept, w_bypass, w_push, w_pop, w_done_nxt;
  logic [DATA_WIDTH-1:0] w_in_data;

  assign w_empty     = (r_count == '0);
  // Registered-only ready: a pop from a full queue does not open a slot in the same cycle.
  assign bus.ready_o = (r_count < Full) && (r_state != StDrain);
  assign w_accept    = bus.valid_i && bus.ready_o;
  assign w_in_data   = bus.mask_e_i ? bus.alu_q_i : bus.old_vd_i;

`ifdef WB_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && w_accept && bus.wb_ready_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push      = w_accept && !w_bypass;
  assign w_pop       = !w_empty && bus.wb_ready_i;
  assign bus.count_o = r_count;
  assign bus.done_o  = r_done;

  always_comb begin
    bus.wb_valid_o = 1'b0;
    bus.wb_data_o  = '0;
    bus.wb_vd_o    = '0;
    bus.wb_elem_o  = '0;
    bus.wb_last_o  = 1'b0;
    if (!w_empty) begin
      bus.wb_valid_o = 1'b1;
      bus.wb_data_o  = r_data[r_rptr];
      bus.wb_vd_o    = r_vd[r_rptr];
      bus.wb_elem_o  = r_elem[r_rptr];
      bus.wb_last_o  = r_last[r_rptr];
    end else if (w_bypass) begin
      bus.wb_valid_o = 1'b1;
      bus.wb_data_o  = w_in_data;
      bus.wb_vd_o    = bus.vd_i;
      bus.wb_elem_o  = bus.elem_i;
      bus.wb_last_o  = bus.last_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      StIdle, StBusy: begin
        if (w_accept) begin
          // A bypassed last element retires immediately, skipping the drain phase.
          if (bus.last_i && w_bypass) begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end else if (bus.last_i) begin
            w_state_nxt = StDrain;
          end else begin
            w_state_nxt = StBusy;
          end
        end
      end
      StDrain: begin
        if (w_pop && r_last[r_rptr]) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= StIdle;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wptr] <= w_in_data;
      r_vd[r_wptr]   <= bus.vd_i;
      r_elem[r_wptr] <= bus.elem_i;
      r_last[r_wptr] <= bus.last_i;
    end
  end
endmodule

// File: doc/vector_wb_queue.md
VECTOR_WB_QUEUE -- requirements
Module: vector_wb_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of ALU result and register-file write data.
REQ-002 Parameter IDX_WIDTH, default 5: element-index width.
REQ-003 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-004 Clock and reset SHALL be: one clock `clk_i`; reset `resetn_i` is asynchronous and active-low.
REQ-005 Port `clk_i`, input, 1: single clock, rising edge.
REQ-006 Port `resetn_i`, input, 1: asynchronous active-low reset.
REQ-007 Port `valid_i`, input, 1: ALU result valid.
REQ-008 Port `ready_o`, output, 1: queue accepts a result.
REQ-009 Port `mask_e_i`, input, 1: element active; 0 means mask-undisturbed.
REQ-010 Port `alu_q_i`, input, DATA_WIDTH: ALU result.
REQ-011 Port `old_vd_i`, input, DATA_WIDTH: prior destination element value.
REQ-012 Port `vd_i`, input, 5: destination register number.
REQ-013 Port `elem_i`, input, IDX_WIDTH: element index.
REQ-014 Port `last_i`, input, 1: final element of the instruction.
REQ-015 Ports `wb_valid_o` (output, 1) and `wb_ready_i` (input, 1): write-back handshake.
REQ-016 Ports `wb_data_o` (output, DATA_WIDTH), `wb_vd_o` (output, 5), `wb_elem_o` (output, IDX_WIDTH), `wb_last_o` (output, 1): write-back payload.
REQ-017 Port `done_o`, output, 1: one-cycle pulse when an instruction has fully retired.
REQ-018 Port `count_o`, output, $clog2(DEPTH)+1: current occupancy.

Function
REQ-019 Push SHALL occur on valid_i && ready_o; pop SHALL occur on wb_valid_o && wb_ready_i; both may occur in the same cycle.
REQ-020 Stored data SHALL be alu_q_i when mask_e_i=1, otherwise old_vd_i; vd_i, elem_i and last_i SHALL be stored unchanged.
REQ-021 Latency SHALL be one cycle: a push at edge N makes the entry visible at the output after edge N when it reaches the FIFO head.
REQ-022 Ordering SHALL be strict FIFO; wb_* outputs SHALL be driven from the head entry and held stable while wb_valid_o=1 and wb_ready_i=0.
REQ-023 Pointers SHALL wrap modulo DEPTH; count_o SHALL change by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-024 State machine IDLE->BUSY SHALL occur on the first push; BUSY->DRAIN SHALL occur on a push with last_i=1; DRAIN->IDLE SHALL occur on a pop with wb_last_o=1.
REQ-025 ready_o SHALL be (count_o<DEPTH) && state!=DRAIN.
REQ-026 When full, a simultaneous pop SHALL NOT allow a push in that cycle; ready_o SHALL depend only on registered state.
REQ-027 When empty, wb_valid_o SHALL be 0 and wb_* payloads SHALL be 0.
REQ-028 done_o SHALL pulse high for exactly the cycle after the DRAIN->IDLE pop.
REQ-029 valid_i while ready_o=0 SHALL be ignored with no state change; the upstream holds its data.

Reset
REQ-030 Asserting resetn_i SHALL, immediately and regardless of clk_i, set state to IDLE, empty the queue with pointers at 0, and drive count_o=0, wb_valid_o=0, wb_* payloads=0, done_o=0 and ready_o=1.
REQ-031 Reset during BUSY or DRAIN SHALL discard all entries; no done_o SHALL be produced for the aborted instruction.

Configuration
REQ-032 Macro WB_QUEUE_BYPASS_EN: when defined, if the queue is empty, valid_i=1 and wb_ready_i=1, the input SHALL pass combinationally to wb_* in the same cycle without being stored, and count_o SHALL be unchanged.
REQ-033 With WB_QUEUE_BYPASS_EN undefined, every element SHALL pass through the FIFO with the one-cycle latency of REQ-021.
REQ-034 State transitions and done_o SHALL behave identically in both builds; a bypassed last element SHALL trigger the DRAIN->IDLE transition directly.

Verification
REQ-035 Masked merge: push alu_q_i=0xDEADBEEF, old_vd_i=0x12345678, mask_e_i=0, then the same with mask_e_i=1 -> wb_data_o=0x12345678, then 0xDEADBEEF.
REQ-036 Full/backpressure: wb_ready_i=0, push 5 elements with DEPTH=4 -> ready_o=0 after the 4th, count_o=4, 5th not accepted until the first pop.
REQ-037 Wrap and ordering: 10 elements, elem_i 0..9, wb_ready_i toggling -> output elem order 0..9, no loss or duplication.
REQ-038 Last/done: last_i=1 on elem 3 -> ready_o=0 until elem 3 popped, done_o single pulse on the next cycle, ready_o=1 after it.
REQ-039 Reset mid-DRAIN: 3 entries queued, assert resetn_i -> count_o=0, wb_valid_o=0, no done_o.
REQ-040 Bypass (WB_QUEUE_BYPASS_EN defined): empty queue, valid_i=1, wb_ready_i=1, alu_q_i=0x5 -> wb_valid_o=1 and wb_data_o=0x5 in the same cycle, count_o stays 0.
